dmem_responder: RTL and testbench

//  Data-memory responder on the CPU's data bus (raddr/re read port, waddr/wdata/we write port).

---
 rtl/dmem_responder_pkg.sv | 36 +++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder_sync_fifo.sv | 50 +++++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared CPU data-bus definitions: bus widths, MMIO register offsets,
// console status bit positions and the address-region decoder.
package cpu_pkg;
   localparam int DADDRWIDTH = 16;
   localparam int DWIDTH     = 16;

   typedef logic [DADDRWIDTH-1:0] daddr_t;
   typedef logic [DWIDTH-1:0]     dword_t;

   localparam logic [7:0] OFF_CON_DATA = 8'h00;
   localparam logic [7:0] OFF_CON_STAT = 8'h01;
   localparam logic [7:0] OFF_CYCLE_LO = 8'h02;
   localparam logic [7:0] OFF_CYCLE_HI = 8'h03;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_NONE
   } region_e;

   // The MMIO window is 256 words starting at base; RAM always sits below it.
   function automatic region_e decode(daddr_t addr, daddr_t base, int ram_depth);
      daddr_t off;
      off = addr - base;
      if (int'(addr) < ram_depth)
         return REG_RAM;
      else if ((addr >= base) && (off[DADDRWIDTH-1:8] == '0))
         return REG_MMIO;
      else
         return REG_NONE;
   endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// CPU data bus (read port, write port) plus the console drain handshake.
interface dmem_responder_if;
   import cpu_pkg::*;

   daddr_t     raddr;
   logic       re;
   dword_t     rdata;
   daddr_t     waddr;
   dword_t     wdata;
   logic       we;
   logic       con_valid;
   logic [7:0] con_data;
   logic       con_ready;

   modport master (
      output raddr, re, waddr, wdata, we, con_ready,
      input  rdata, con_valid, con_data
   );

   modport slave (
      input  raddr, re, waddr, wdata, we, con_ready,
      output rdata, con_valid, con_data
   );
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Single-clock FIFO; push while full succeeds only if a pop frees the slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head reads zero while empty so stale storage never leaks out after reset.
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO console FIFO, status and cycle counter.
module dmem_responder
   import cpu_pkg::*;
#(
   parameter int          RAM_DEPTH  = 4096,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);
   localparam int RAW = $clog2(RAM_DEPTH);

   dword_t                     ram [RAM_DEPTH];
   logic [31:0]                cycle;
   dword_t                     cyc_hi_shadow;
   logic                       overflow;
   logic                       full;
   logic                       empty;
   logic [7:0]                 head;
   logic [$clog2(FIFO_DEPTH):0] count;

   region_e    rreg;
   region_e    wreg;
   logic [7:0] roff;
   logic [7:0] woff;
   dword_t     rd_val;
   dword_t     stat;
   logic       con_push;
   logic       con_pop;
   logic       stat_clr;
   logic       ovf_set;
   logic       lo_rd;

   always_comb begin
      rreg = decode(bus.raddr, MMIO_BASE, RAM_DEPTH);
      wreg = decode(bus.waddr, MMIO_BASE, RAM_DEPTH);
      roff = 8'(bus.raddr - MMIO_BASE);
      woff = 8'(bus.waddr - MMIO_BASE);

      stat = '0;
      stat[STAT_EMPTY] = empty;
      stat[STAT_FULL]  = full;
      stat[STAT_OVF]   = overflow;

      rd_val = '0;
      case (rreg)
         REG_RAM:  rd_val = ram[bus.raddr[RAW-1:0]];
         REG_MMIO: begin
            case (roff)
               OFF_CON_STAT: rd_val = stat;
               OFF_CYCLE_LO: rd_val = cycle[15:0];
               OFF_CYCLE_HI: rd_val = cyc_hi_shadow;
               default:      rd_val = '0;
            endcase
         end
         default: rd_val = '0;
      endcase

      con_push = bus.we && (wreg == REG_MMIO) && (woff == OFF_CON_DATA);
      stat_clr = bus.we && (wreg == REG_MMIO) && (woff == OFF_CON_STAT);
      lo_rd    = bus.re && (rreg == REG_MMIO) && (roff == OFF_CYCLE_LO);
      con_pop  = bus.con_ready && !empty;
      // A full FIFO still accepts a byte when the consumer frees a slot on the same edge.
      ovf_set  = con_push && full && !con_pop;
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_con_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (con_push),
      .push_data (bus.wdata[7:0]),
      .pop       (con_pop),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .count     (count)
   );

   assign bus.con_valid = (count != '0);
   assign bus.con_data  = head;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.rdata     <= '0;
         cycle         <= '0;
         cyc_hi_shadow <= '0;
         overflow      <= 1'b0;
      end else begin
         if (bus.re) bus.rdata <= rd_val;
         // Snapshot the upper half so a LO-then-HI read pair is coherent.
         if (lo_rd) cyc_hi_shadow <= cycle[31:16];
         cycle <= cycle + 32'd1;
         if (ovf_set)
            overflow <= 1'b1;
         else if (stat_clr)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && bus.we && (wreg == REG_RAM)) ram[bus.waddr[RAW-1:0]] <= bus.wdata;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;
   import cpu_pkg::*;

   localparam logic [15:0] MB = 16'hFF00;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if bus();

   dmem_responder #(
      .RAM_DEPTH  (4096),
      .FIFO_DEPTH (8),
      .MMIO_BASE  (MB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   logic [15:0] m_ram [int];
   logic [7:0]  mq [$];
   logic [31:0] m_cycle  = 0;
   logic [15:0] m_shadow = 0;
   logic [15:0] m_rdata  = 0;
   logic        m_ovf    = 0;

   function automatic logic [15:0] m_read(input logic [15:0] a);
      if (a < 16'd4096) return m_ram.exists(int'(a)) ? m_ram[int'(a)] : 16'h0000;
      if (a >= MB) begin
         case (int'(a - MB))
            1:       return {13'b0, m_ovf, (mq.size() == 8), (mq.size() == 0)};
            2:       return m_cycle[15:0];
            3:       return m_shadow;
            default: return 16'h0000;
         endcase
      end
      return 16'h0000;
   endfunction

   // Advance the model by one edge from the current inputs, clock, then compare.
   task automatic tick(input bit do_chk = 1'b1);
      logic [15:0] rv;
      bit          pop;
      bit          full_pre;
      if (!rst) begin
         m_rdata  = 0;
         mq.delete();
         m_ovf    = 0;
         m_cycle  = 0;
         m_shadow = 0;
      end else begin
         rv = m_read(bus.raddr);
         if (bus.re) begin
            if (bus.raddr == MB + 16'd2) m_shadow = m_cycle[31:16];
            m_rdata = rv;
         end
         full_pre = (mq.size() == 8);
         pop = bus.con_ready && (mq.size() > 0);
         if (pop) void'(mq.pop_front());
         if (bus.we) begin
            if (bus.waddr < 16'd4096)
               m_ram[int'(bus.waddr)] = bus.wdata;
            else if (bus.waddr == MB) begin
               if (!full_pre || pop) mq.push_back(bus.wdata[7:0]);
               else m_ovf = 1'b1;
            end else if (bus.waddr == MB + 16'd1)
               m_ovf = 1'b0;
         end
         m_cycle = m_cycle + 1;
      end
      @(posedge clk);
      #1;
      if (do_chk) begin
         check("rdata", bus.rdata, m_rdata);
         check("con_valid", bus.con_valid, (mq.size() > 0));
         check("con_data", bus.con_data, (mq.size() > 0) ? mq[0] : 8'h00);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.re = 1'b0;
      tick();
      bus.we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      bus.re = 1'b1; bus.raddr = a; bus.we = 1'b0;
      tick();
      bus.re = 1'b0;
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: return 16'($urandom_range(0, 31));
         6, 7:             return MB + 16'($urandom_range(0, 5));
         8:                return 16'h1000;
         default:          return 16'hFEFF;
      endcase
   endfunction

   initial begin
      bus.re = 0; bus.we = 0; bus.raddr = 0; bus.waddr = 0; bus.wdata = 0; bus.con_ready = 0;

      rst = 1'b0;
      tick(); tick();
      check("rst_rdata", bus.rdata, 16'h0000);
      check("rst_con_valid", bus.con_valid, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < 32; i++) wr(16'(i), 16'($urandom));

      wr(16'h0010, 16'hBEEF);
      rd(16'h0010);
      check("ram_read", bus.rdata, 16'hBEEF);
      tick();
      check("rdata_hold", bus.rdata, 16'hBEEF);

      wr(16'h0020, 16'h5555);
      bus.we = 1'b1; bus.waddr = 16'h0020; bus.wdata = 16'h1234;
      bus.re = 1'b1; bus.raddr = 16'h0020;
      tick();
      bus.we = 1'b0; bus.re = 1'b0;
      check("rbw_old", bus.rdata, 16'h5555);
      rd(16'h0020);
      check("rbw_new", bus.rdata, 16'h1234);

      bus.con_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(MB, 16'(8'h41 + i));
      rd(MB + 16'd1);
      check("stat_full_ovf", bus.rdata, 16'h0006);
      wr(MB + 16'd1, 16'hFFFF);
      rd(MB + 16'd1);
      check("stat_ovf_clr", bus.rdata, 16'h0002);
      bus.con_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_order", bus.con_data, 8'(8'h41 + i));
         tick();
      end
      bus.con_ready = 1'b0;
      check("drain_empty", bus.con_valid, 1'b0);

      for (int i = 0; i < 8; i++) wr(MB, 16'(8'h61 + i));
      bus.con_ready = 1'b1;
      wr(MB, 16'h005A);
      bus.con_ready = 1'b0;
      rd(MB + 16'd1);
      check("stat_full_pushpop", bus.rdata, 16'h0002);
      bus.con_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_pushpop", bus.con_data, (i < 7) ? 8'(8'h62 + i) : 8'h5A);
         tick();
      end

      wr(MB, 16'h0033);
      check("empty_push", bus.con_valid, 1'b1);
      tick();
      bus.con_ready = 1'b0;

      for (int i = 0; i < 3; i++) wr(MB, 16'(8'h70 + i));
      rd(16'h0010);
      bus.re = 1'b1; bus.raddr = 16'h0020;
      bus.we = 1'b1; bus.waddr = 16'h0010; bus.wdata = 16'hDEAD;
      rst = 1'b0;
      tick();
      bus.re = 1'b0; bus.we = 1'b0;
      check("midrst_rdata", bus.rdata, 16'h0000);
      check("midrst_valid", bus.con_valid, 1'b0);
      rst = 1'b1;
      rd(MB + 16'd1);
      check("midrst_stat", bus.rdata, 16'h0001);
      rd(16'h0010);
      check("midrst_nowrite", bus.rdata, 16'hBEEF);

      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 99) != 0);
         bus.re = $urandom_range(0, 1);
         bus.we = $urandom_range(0, 1);
         bus.raddr = pick_addr();
         bus.waddr = ($urandom_range(0, 2) == 0) ? MB : pick_addr();
         bus.wdata = 16'($urandom);
         bus.con_ready = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b1; bus.re = 1'b0; bus.we = 1'b0; bus.con_ready = 1'b0;

      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int n = 0; n < 32'h10005; n++) tick(1'b0);
      rd(MB + 16'd2);
      check("cycle_lo", bus.rdata, 16'h0005);
      rd(MB + 16'd3);
      check("cycle_hi", bus.rdata, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
